serial_add_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit ripple adder over WIDTH/4 clock cycles, least-significant nibble first, with the carry held in a register between nibbles. It sits between a requesting control unit and the shared nibble adder. It provides a start/busy/done handshake and registered sum, carry-out and signed-overflow results.

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/serial_add_ctrl_nibble_adder.sv | 33 +++
 rtl/serial_add_ctrl.sv | 149 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg
//   Shared definitions for the nibble-serial add/subtract sequencer:
//   the controller FSM state type and the width of the shared adder slice.
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_nibble_adder.sv
// nibble_adder
//   4-bit ripple-carry adder shared by the serial sequencer.
//   Ports:
//     a, b  4-bit operands
//     ci    carry into bit 0
//     s     4-bit sum
//     co    carry out of bit 3
//     c3    carry into bit 3 (XOR with co gives signed overflow of the slice)
module nibble_adder
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co,
  output logic                c3
);

  always_comb begin : ripple
    logic [NIBBLE_W:0] c;
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    co = c[NIBBLE_W];
    c3 = c[NIBBLE_W-1];
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   WIDTH-bit add/subtract computed one nibble per clock through a single
//   shared 4-bit adder, least-significant nibble first, with the carry held
//   in a register between nibbles. Start/busy/done handshake; results are
//   registered and held until the next operation completes.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; results from the last operation held
//   RUN   | one nibble per edge; leaves after nibble NIB-1 with done
//
//   Ports:
//     clk, rst  rising-edge clock, synchronous active-high reset
//     start     request, sampled only while idle
//     a, b      operands, sampled with start
//     cin       carry in, sampled with start (ignored for subtract)
//     sub       1 = a - b
//     busy      high while nibbles are being processed
//     done      one-cycle pulse when sum/cout/ovf update
//     sum       WIDTH-bit result
//     cout      carry out of the MSB (subtract: 1 = no borrow)
//     ovf       two's-complement overflow
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   res_r;
  logic               carry_r;

  logic               load;
  logic               step;
  logic               last;

  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_co;
  logic                nib_c3;
  logic [WIDTH-1:0]    res_next;

  nibble_adder u_nibble_adder (
    .a  (a_r[NIBBLE_W-1:0]),
    .b  (b_r[NIBBLE_W-1:0]),
    .ci (carry_r),
    .s  (nib_s),
    .co (nib_co),
    .c3 (nib_c3)
  );

  // Each new nibble enters at the top, so after NIB steps the first
  // (least-significant) nibble has reached bit 0.
  assign res_next = {nib_s, res_r[WIDTH-1:NIBBLE_W]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST_NIB) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    step = 1'b0;
    last = 1'b0;
    case (state_q)
      IDLE: load = start;
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        last = (cnt_q == LAST_NIB);
      end
      default: ;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // Subtract is a + ~b + 1; the caller's cin plays no part.
        a_r     <= a;
        b_r     <= sub ? ~b : b;
        carry_r <= sub ? 1'b1 : cin;
        cnt_q   <= '0;
      end else if (step) begin
        a_r     <= a_r >> NIBBLE_W;
        b_r     <= b_r >> NIBBLE_W;
        res_r   <= res_next;
        carry_r <= nib_co;
        cnt_q   <= cnt_q + 1'b1;
        if (last) begin
          done <= 1'b1;
          sum  <= res_next;
          cout <= nib_co;
          // On the top nibble, carry into bit 3 is the carry into the MSB.
          ovf  <= nib_co ^ nib_c3;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_vec = 0;
  int n_err = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  // Reference: arithmetic on the operands, returns {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                          input logic rcin, input logic rsub);
    logic [W-1:0] bb;
    logic [W:0]   t;
    logic         v;
    bb = rsub ? ~rb : rb;
    t  = {1'b0, ra} + {1'b0, bb} + (W+1)'(rsub ? 1'b1 : rcin);
    v  = (ra[W-1] == bb[W-1]) && (t[W-1] != ra[W-1]);
    return {v, t[W], t[W-1:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic scramble_inputs();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // Start one operation, let the inputs wander, wait for done and compare.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                        input logic tsub, input logic [W-1:0] es, input logic ec,
                        input logic eo, input string tag);
    int lat;
    bit seen;
    logic [W-1:0] prev_sum;
    @(negedge clk);
    prev_sum = sum;
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_sum_held"}, 32'(sum), 32'(prev_sum));
    lat = 0;
    seen = 0;
    while (!seen && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(NIB));
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int dcount;
    int rem;
    logic [W+1:0] r;
    logic [W+1:0] pend [$];
    logic [W+1:0] e;

    vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    dcount = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    chk("idle_no_activity", 32'(dcount), 32'd0);

    // Directed table
    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, $sformatf("vec%0d", i));

    // Random operations against the reference
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      r = ref_op(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, r[W-1:0], r[W], r[W+1], $sformatf("rnd%0d", i));
    end

    // start held high with fresh operands every cycle: only operands at
    // accepting edges count, and the done cycle itself accepts.
    rem = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bit exp_done;
      @(negedge clk);
      start = 1'b1;
      scramble_inputs();
      @(posedge clk);
      exp_done = 0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) exp_done = 1;
      end else begin
        pend.push_back(ref_op(a, b, cin, sub));
        rem = NIB;
      end
      #1;
      chk($sformatf("b2b_busy%0d", cyc), 32'(busy), 32'(rem > 0));
      chk($sformatf("b2b_done%0d", cyc), 32'(done), 32'(exp_done));
      if (exp_done && pend.size() > 0) begin
        e = pend.pop_front();
        chk($sformatf("b2b_res%0d", cyc), {14'd0, ovf, cout, sum}, 32'(e));
      end
    end
    @(negedge clk); start = 1'b0;
    repeat (NIB + 2) @(posedge clk);

    // Reset in the middle of RUN discards the operation
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, "pre_rst");
    @(negedge clk);
    a = 16'h4321; b = 16'h1234; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    @(negedge clk); rst = 1'b0;
    dcount = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    chk("midrst_no_done", 32'(dcount), 32'd0);

    // rst wins over a simultaneous start
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("rst_vs_start_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0; start = 1'b0;

    r = ref_op(16'hABCD, 16'h1234, 1'b1, 1'b0);
    run_op(16'hABCD, 16'h1234, 1'b1, 1'b0, r[W-1:0], r[W], r[W+1], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
